// File: rtl/exu_gpr_wb.sv
// Write-back stage: one-entry valid/ready holding register in front of the
// integer register file, with read-port forwarding and a retired-instruction counter.
module exu_gpr_wb #(
  parameter int XLEN    = 32,
  parameter int GPR_NUM = 32,
  parameter int PC_SIZE = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ex_valid,
  output logic               ex_ready,
  input  logic [PC_SIZE-1:0] ex_pc,
  input  logic               ex_gpr_wen,
  input  logic [4:0]         ex_gpr_waddr,
  input  logic [XLEN-1:0]    ex_gpr_wdata,
  input  logic               flush,
  input  logic [4:0]         rs1_addr,
  output logic [XLEN-1:0]    rs1_data,
  input  logic [4:0]         rs2_addr,
  output logic [XLEN-1:0]    rs2_data,
  output logic               ret_valid,
  input  logic               ret_ready,
  output logic [PC_SIZE-1:0] ret_pc,
  output logic               ret_gpr_wen,
  output logic [4:0]         ret_gpr_waddr,
  output logic [XLEN-1:0]    ret_gpr_wdata,
  output logic [63:0]        instret
);

  logic               wb_valid_q;
  logic [PC_SIZE-1:0] wb_pc_q;
  logic               wb_wen_q;
  logic [4:0]         wb_waddr_q;
  logic [XLEN-1:0]    wb_wdata_q;
  logic [63:0]        instret_q;
  logic [63:0]        instret_d;
  logic [XLEN-1:0]    gpr_q [GPR_NUM];

  logic accept;
  logic retire;

  assign ex_ready  = !flush && (!wb_valid_q || ret_ready);
  assign accept    = ex_valid && ex_ready;
  // Flush outranks a pending retire handshake.
  assign retire    = wb_valid_q && ret_ready && !flush;
  assign instret_d = instret_q + 64'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid_q <= 1'b0;
      wb_pc_q    <= '0;
      wb_wen_q   <= 1'b0;
      wb_waddr_q <= '0;
      wb_wdata_q <= '0;
      instret_q  <= '0;
    end else begin
      if (flush) begin
        wb_valid_q <= 1'b0;
      end else if (accept) begin
        wb_valid_q <= 1'b1;
        wb_pc_q    <= ex_pc;
        // x0 writes are masked at capture so ret_gpr_wen already reflects them.
        wb_wen_q   <= ex_gpr_wen && (ex_gpr_waddr != 5'd0);
        wb_waddr_q <= ex_gpr_waddr;
        wb_wdata_q <= ex_gpr_wdata;
      end else if (retire) begin
        wb_valid_q <= 1'b0;
      end
      if (retire) begin
        instret_q <= instret_d;
      end
    end
  end

  // Register file; entry 0 is a constant zero.
  for (genvar gi = 0; gi < GPR_NUM; gi++) begin : g_gpr
    if (gi == 0) begin : g_zero
      always_ff @(posedge clk) begin
        gpr_q[gi] <= '0;
      end
    end else begin : g_reg
      always_ff @(posedge clk) begin
        if (rst) begin
          gpr_q[gi] <= '0;
        end else if (retire && wb_wen_q && (wb_waddr_q == 5'(gi))) begin
          gpr_q[gi] <= wb_wdata_q;
        end
      end
    end
  end

  logic [4:0]      rd_addr [2];
  logic [XLEN-1:0] rd_data [2];

  assign rd_addr[0] = rs1_addr;
  assign rd_addr[1] = rs2_addr;
  assign rs1_data   = rd_data[0];
  assign rs2_data   = rd_data[1];

  // Forward only from the held entry, never from the ex_* inputs.
  for (genvar gi = 0; gi < 2; gi++) begin : g_rd
    always_comb begin
      rd_data[gi] = '0;
      if (rd_addr[gi] != 5'd0) begin
        if (wb_valid_q && wb_wen_q && (wb_waddr_q == rd_addr[gi])) begin
          rd_data[gi] = wb_wdata_q;
        end else begin
          rd_data[gi] = gpr_q[rd_addr[gi]];
        end
      end
    end
  end

  assign ret_valid     = wb_valid_q;
  assign ret_pc        = wb_pc_q;
  assign ret_gpr_wen   = wb_wen_q;
  assign ret_gpr_waddr = wb_waddr_q;
  assign ret_gpr_wdata = wb_wdata_q;
  assign instret       = instret_q;

endmodule
